// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester agent.
// Latency: n/a (constants, types and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents: requester FSM state encoding, default parameter values, and a
// ceil-log2 helper used to size pointers and counters.
package arb_pkg;

  // Default geometry for a requester instance.
  localparam int ARB_LEN_W   = 4;   // burst length field width (len = beats - 1)
  localparam int ARB_DEPTH   = 4;   // command FIFO entries, power of two >= 2
  localparam int ARB_TIMEOUT = 16;  // max REQ cycles without grant, >= 2

  // Requester FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Ceil(log2(value)), never less than 1, so that a value of 1 or 2 still
  // yields a usable one-bit field.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: synchronous queue of burst lengths with full/empty flags.
// Latency: a pushed entry is visible on o_dout the cycle after the push.
// Backpressure: pushes while full are ignored, pops while empty are ignored.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset (pointers and count clear)
//   i_push   in   write request; accepted only when not full
//   i_din    in   WIDTH-bit entry to write
//   i_pop    in   read request; honoured only when not empty
//   o_dout   out  head entry (valid whenever o_empty is low)
//   o_full   out  DEPTH entries held
//   o_empty  out  no entries held
module cmd_fifo
  import arb_pkg::*;
#(
  parameter int WIDTH = ARB_LEN_W,
  parameter int DEPTH = ARB_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  // Pointer width covers DEPTH entries; the count needs one extra state
  // to tell full apart from empty.
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rptr];

  // Guarding with the flags keeps a push-while-full or pop-while-empty from
  // moving a pointer and corrupting the queue.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset: an entry is only ever read after it has been
  // written, because the count gates every pop.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // DEPTH is a power of two, so plain AW-bit increments wrap modulo DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Requester agent: queues burst commands, requests the arbiter, and streams
// one beat per granted cycle. It resumes after a grant is withdrawn and
// drops a job on grant timeout.
// Latency: a command into an idle, empty agent gives req at +2 cycles; with
// gnt high the first beat follows at +3.
// Backpressure: cmd_ready falls while the FIFO is full. gnt low stalls beats.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset, clears everything
//   cmd_valid   in   command offered
//   cmd_len     in   burst length minus one
//   cmd_ready   out  command FIFO has room
//   req         out  registered request to the arbiter
//   gnt         in   grant from the arbiter
//   beat_valid  out  a bus beat happens this cycle (BUSY and gnt)
//   beat_idx    out  0-based index of the current beat
//   done        out  pulse with the last beat of a burst
//   timeout     out  pulse when a job is dropped for lack of grant
//   busy        out  job in flight or commands pending
module arb_requester
  import arb_pkg::*;
#(
  parameter int LEN_W   = ARB_LEN_W,
  parameter int DEPTH   = ARB_DEPTH,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  // Timeout counter only has to reach TIMEOUT-1.
  localparam int TW = clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_GAP  = ST_GAP;

  logic [1:0]       r_state;
  logic             r_req;
  logic [LEN_W-1:0] r_len_q;
  logic [LEN_W-1:0] r_beat_idx;
  logic [TW-1:0]    r_tcnt;

  logic [1:0]       w_state_nxt;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [LEN_W-1:0] w_fifo_dout;
  logic             w_pop;
  logic             w_beat;
  logic             w_last;
  logic             w_tmo;

  // Jobs are only taken from the queue while idle, so at most one burst is
  // ever in flight and the head stays stable until then.
  assign w_pop = (r_state == S_IDLE) && !w_fifo_empty;

  cmd_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (cmd_valid),
    .i_din   (cmd_len),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // A grant only produces a beat once the FSM has reached BUSY. The REQ
  // cycle that first sees gnt is spent moving there, which also applies
  // after a preemption.
  assign w_beat = (r_state == S_BUSY) && gnt;
  assign w_last = w_beat && (r_beat_idx == r_len_q);

  // Fires on the TIMEOUT-th consecutive ungranted REQ cycle. done needs
  // BUSY while this needs REQ, so the two pulses can never coincide.
  assign w_tmo  = (r_state == S_REQ) && !gnt && (r_tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (gnt) begin
          w_state_nxt = S_BUSY;
        end else if (w_tmo) begin
          w_state_nxt = S_GAP;
        end
      end
      S_BUSY: begin
        // Losing the grant mid-burst goes back to requesting. beat_idx is
        // held, so the burst continues where it stopped.
        if (!gnt) begin
          w_state_nxt = S_REQ;
        end else if (w_last) begin
          w_state_nxt = S_GAP;
        end
      end
      default: begin
        // GAP: one cycle with req low, so the arbiter always sees req
        // drop between jobs.
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_len_q    <= '0;
      r_beat_idx <= '0;
      r_tcnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      // req is registered from the next state, so it is high exactly while
      // the FSM sits in REQ or BUSY.
      r_req   <= (w_state_nxt == S_REQ) || (w_state_nxt == S_BUSY);

      case (r_state)
        S_IDLE: begin
          if (!w_fifo_empty) begin
            r_len_q    <= w_fifo_dout;
            r_beat_idx <= '0;
            r_tcnt     <= '0;
          end
        end
        S_REQ: begin
          if (gnt) begin
            r_tcnt <= '0;
          end else if (!w_tmo) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_BUSY: begin
          if (!gnt) begin
            r_tcnt <= '0;
          end else if (!w_last) begin
            // Holding at the final index means beat_idx never wraps, even
            // for a full 2^LEN_W-beat burst.
            r_beat_idx <= r_beat_idx + LEN_W'(1);
          end
        end
        default: begin
          r_tcnt <= r_tcnt;
        end
      endcase
    end
  end

  assign cmd_ready  = !w_fifo_full;
  assign req        = r_req;
  assign beat_valid = w_beat;
  assign beat_idx   = r_beat_idx;
  assign done       = w_last;
  assign timeout    = w_tmo;
  assign busy       = (r_state != S_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester. Random commands and grant patterns are driven
// into the agent. A reference model derived from the agent's request and
// grant rules predicts req/cmd_ready/busy each cycle. It also queues the
// expected beat and timeout events, which a monitor matches against the DUT.
module tb_arb_requester;

  localparam int LEN_W   = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic             clock     = 1'b0;
  logic             reset     = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len   = '0;
  logic             gnt       = 1'b0;
  logic             cmd_ready;
  logic             req;
  logic             beat_valid;
  logic [LEN_W-1:0] beat_idx;
  logic             done;
  logic             timeout;
  logic             busy;

  arb_requester #(
    .LEN_W   (LEN_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .req        (req),
    .gnt        (gnt),
    .beat_valid (beat_valid),
    .beat_idx   (beat_idx),
    .done       (done),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_to;
    int idx;
    bit last;
  } ev_t;

  ev_t evq[$];   // expected beat / timeout events, in order
  int  mq[$];    // model of the command queue (burst lengths)

  int n_checks = 0;
  int n_fail   = 0;
  bit stim_done  = 1'b0;
  bit model_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // One model cycle: check the level outputs against the model, accept a
  // command if the modelled queue had room, optionally pop, then advance.
  task automatic tick(input bit exp_req, input bit active, input bit do_pop);
    bit exp_rdy;
    exp_rdy = (mq.size() < DEPTH);
    check("req", req, exp_req);
    check("cmd_ready", cmd_ready, exp_rdy);
    check("busy", busy, (active || mq.size() != 0));
    if (cmd_valid && exp_rdy) mq.push_back(int'(cmd_len));
    if (do_pop) void'(mq.pop_front());
    @(negedge clock);
  endtask

  // Reference behaviour of one agent:
  //  - while idle, the oldest command is taken; req rises the cycle after.
  //  - a beat happens on any cycle with gnt when the previous job cycle
  //    also had gnt. The first job cycle counts as "previous gnt = 0".
  //  - ungranted cycles that follow an ungranted (or first) cycle count
  //    toward the timeout. Any other cycle restarts the count.
  //  - after the last beat or a timeout, req is low for one cycle.
  task automatic model_run();
    int len, idx, lows;
    bit prev, fin;
    ev_t e;
    @(negedge clock);
    forever begin
      if (mq.size() == 0) begin
        if (stim_done) break;
        tick(1'b0, 1'b0, 1'b0);
        continue;
      end
      len = mq[0];
      tick(1'b0, 1'b0, 1'b1);
      idx = 0; lows = 0; prev = 1'b0; fin = 1'b0;
      while (!fin) begin
        if (gnt && prev) begin
          e.cyc = cyc; e.is_to = 1'b0; e.idx = idx; e.last = (idx == len);
          evq.push_back(e);
          if (idx == len) fin = 1'b1;
          else idx++;
        end else if (!gnt && !prev) begin
          lows++;
          if (lows == TIMEOUT) begin
            e.cyc = cyc; e.is_to = 1'b1; e.idx = 0; e.last = 1'b0;
            evq.push_back(e);
            fin = 1'b1;
          end
        end else begin
          lows = 0;
        end
        prev = gnt;
        tick(1'b1, 1'b1, 1'b0);
      end
      tick(1'b0, 1'b1, 1'b0);
    end
    model_done = 1'b1;
  endtask

  task automatic monitor_run();
    ev_t e;
    while (!model_done) begin
      @(negedge clock);
      #1;
      if (beat_valid || timeout || done) begin
        if (evq.size() == 0) begin
          check("spurious_output", int'({beat_valid, timeout, done}), 0);
        end else begin
          e = evq.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("timeout", timeout, e.is_to);
          if (e.is_to) begin
            check("beat_on_timeout", beat_valid, 0);
            check("done_on_timeout", done, 0);
          end else begin
            check("beat_valid", beat_valid, 1);
            check("beat_idx", beat_idx, e.idx);
            check("done", done, e.last);
          end
        end
      end
    end
  endtask

  task automatic stim_run();
    int mode;
    // Single 4-beat burst with gnt tied high, then a burst of pushes with
    // gnt low to fill the queue and force timeouts.
    for (int k = 0; k < 60; k++) begin
      @(posedge clock); #1;
      if (k < 30) begin
        cmd_valid = (k == 0);
        cmd_len   = LEN_W'(3);
        gnt       = 1'b1;
      end else begin
        cmd_valid = (k < 36);
        cmd_len   = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
        gnt       = 1'b0;
      end
    end
    // Random segments: steady grant, choppy grant, sparse grant, no grant.
    for (int s = 0; s < 14; s++) begin
      mode = $urandom_range(0, 3);
      for (int k = 0; k < 100; k++) begin
        @(posedge clock); #1;
        cmd_valid = ($urandom_range(0, 99) < 30);
        cmd_len   = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
        case (mode)
          0:       gnt = 1'b1;
          1:       gnt = ($urandom_range(0, 99) < 75);
          2:       gnt = ($urandom_range(0, 99) < 8);
          default: gnt = 1'b0;
        endcase
      end
    end
    // Drain with a steady grant.
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    gnt       = 1'b1;
    repeat (200) @(posedge clock);
    stim_done = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;

    // Values held in reset.
    repeat (3) @(negedge clock);
    #1;
    check("rst_req", req, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_beat_idx", beat_idx, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_beat_valid", beat_valid, 0);
    reset = 1'b1;

    fork
      stim_run();
      model_run();
      monitor_run();
    join
    check("events_drained", evq.size(), 0);

    // Reset pulled mid-burst while a second command is still queued.
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_len = LEN_W'(7); gnt = 1'b1;
    @(posedge clock); #1;
    cmd_len = LEN_W'(2);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (beat_valid && beat_idx == LEN_W'(2)) found = 1'b1;
    end
    check("reach_beat2", found, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_req", req, 0);
    check("arst_beat_valid", beat_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_timeout", timeout, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    @(negedge clock); #1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("post_rst_req", req, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_beat_valid", beat_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
